div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port x, input, 32 bits: signed two's-complement dividend.
REQ-004 SHALL have port y, input, 32 bits: signed two's-complement divisor.
REQ-005 SHALL have port div_control, input, 1 bit: start request, sampled on the rising edge of clk.
REQ-006 SHALL have port hi, output, 32 bits: signed remainder of the last completed division.
REQ-007 SHALL have port lo, output, 32 bits: signed quotient of the last completed division.
REQ-008 SHALL have port operando, output, 1 bit: 1 while a division is in progress.
REQ-009 SHALL have port div_zero, output, 1 bit: 1 when the last accepted request had y == 0.
REQ-010 SHALL have parameter N, default 32, meaning the operand width and the iteration count.

Function
REQ-011 SHALL implement states IDLE, RUN and FIX.
REQ-012 SHALL, in IDLE with div_control=1 and y!=0, latch |x| and |y| in one edge (edge 0), record quotient sign = x[31]^y[31] and remainder sign = x[31], set operando=1 and div_zero=0, and go to RUN.
REQ-013 SHALL, in IDLE with div_control=1 and y==0, set div_zero=1, keep operando=0, hold hi/lo and stay in IDLE.
REQ-014 SHALL perform one restoring step per cycle in RUN for exactly N edges (edges 1..32):
- shift {R,Q} left by 1;
- compute the trial value R−|y| using a 33-bit remainder R;
- if the trial is ≥0, set R to the trial and Q[0]=1; otherwise Q[0]=0.
REQ-015 SHALL, in FIX (edge 33), write lo = Q negated if the quotient sign is set, and hi = R[31:0] negated if the remainder sign is set; it then sets operando=0 and returns to IDLE.
REQ-016 SHALL make hi and lo valid, with operando=0, after edge 33; operando is high for exactly 33 cycles.
REQ-017 SHALL truncate the quotient toward zero, and the nonzero remainder SHALL take the sign of the dividend.
REQ-018 SHALL produce lo=0x80000000 and hi=0 for 0x80000000 / 0xFFFFFFFF (the wrap result).
REQ-019 SHALL ignore div_control while operando=1; x and y changes after edge 0 SHALL NOT affect the result.
REQ-020 SHALL hold hi, lo and div_zero stable in IDLE until the next accepted request.
REQ-021 SHALL accept a new request on the first edge after FIX when div_control stays high, giving back-to-back operation.

Reset
REQ-022 SHALL, on reset=0, immediately force hi=0, lo=0, operando=0, div_zero=0, internal R/Q/counter to 0 and the state to IDLE, regardless of clk.
REQ-023 SHALL abort any operation in progress on reset assertion with no partial result on hi/lo.
REQ-024 SHALL NOT accept div_control on the first rising edge after reset deassertion unless reset was high at that edge.

Structure
REQ-025 SHALL take the state enum (IDLE, RUN, FIX), the width constant N=32 and the iteration-counter width (6 bits) from shared package div_pkg, which the multiplier may also import.
REQ-026 SHALL be a single module with no sub-module; the restoring step is inline combinational logic.

Verification
REQ-027 SHALL cover the following directed cases:
- x=100, y=7 -> lo=14, hi=2, operando low after edge 33.
- x=-100 (0xFFFFFF9C), y=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- x=100, y=-7 -> lo=0xFFFFFFF2, hi=2.
- x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0.
- x=5, y=0 -> div_zero=1, operando stays 0, hi/lo unchanged.
- Start 100/7, assert reset=0 mid-run (cycle 10) -> hi=lo=0, operando=0; after release, 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider
// (also importable by the multiplier).
package div_pkg;

    localparam int unsigned DIV_N     = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div.sv
// Signed restoring divider: one quotient bit per cycle, magnitudes internally,
// signs re-applied in a final FIX cycle (quotient truncates toward zero).
module div
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         div_control,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         operando,
    output logic         div_zero
);

    div_state_e             r_state;
    div_state_e             w_state_nx;
    logic [N:0]             r_rem;
    logic [N:0]             w_rem_nx;
    logic [N-1:0]           r_quo;
    logic [N-1:0]           w_quo_nx;
    logic [N-1:0]           r_dvs;
    logic [N-1:0]           w_dvs_nx;
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic [DIV_CNT_W-1:0]   w_cnt_nx;
    logic                   r_qsign;
    logic                   w_qsign_nx;
    logic                   r_rsign;
    logic                   w_rsign_nx;
    logic [N-1:0]           w_hi_nx;
    logic [N-1:0]           w_lo_nx;
    logic                   w_operando_nx;
    logic                   w_div_zero_nx;

    logic [N:0]             w_rem_sh;
    logic [N:0]             w_trial;
    logic [N-1:0]           w_quo_sh;

    function automatic logic [N-1:0] abs_val(input logic [N-1:0] v);
        logic [N-1:0] res;
        if (v[N-1]) begin
            res = -v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Restoring step: the 33-bit remainder keeps the sign of the trial subtraction
    always_comb begin
        w_rem_sh = {r_rem[N-1:0], r_quo[N-1]};
        w_quo_sh = {r_quo[N-2:0], 1'b0};
        w_trial  = w_rem_sh - {1'b0, r_dvs};
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nx    = r_state;
        w_rem_nx      = r_rem;
        w_quo_nx      = r_quo;
        w_dvs_nx      = r_dvs;
        w_cnt_nx      = r_cnt;
        w_qsign_nx    = r_qsign;
        w_rsign_nx    = r_rsign;
        w_hi_nx       = hi;
        w_lo_nx       = lo;
        w_operando_nx = operando;
        w_div_zero_nx = div_zero;
        case (r_state)
            IDLE: begin
                if (div_control) begin
                    if (y == '0) begin
                        w_div_zero_nx = 1'b1;
                    end else begin
                        w_rem_nx      = '0;
                        w_quo_nx      = abs_val(x);
                        w_dvs_nx      = abs_val(y);
                        w_cnt_nx      = '0;
                        w_qsign_nx    = x[N-1] ^ y[N-1];
                        w_rsign_nx    = x[N-1];
                        w_operando_nx = 1'b1;
                        w_div_zero_nx = 1'b0;
                        w_state_nx    = RUN;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RUN: begin
                if (!w_trial[N]) begin
                    w_rem_nx = w_trial;
                    w_quo_nx = w_quo_sh | {{(N-1){1'b0}}, 1'b1};
                end else begin
                    w_rem_nx = w_rem_sh;
                    w_quo_nx = w_quo_sh;
                end
                w_cnt_nx = r_cnt + DIV_CNT_W'(1);
                if (r_cnt == DIV_CNT_W'(N - 1)) begin
                    w_state_nx = FIX;
                end else begin
                    w_state_nx = RUN;
                end
            end
            FIX: begin
                w_lo_nx       = r_qsign ? -r_quo : r_quo;
                w_hi_nx       = r_rsign ? -r_rem[N-1:0] : r_rem[N-1:0];
                w_operando_nx = 1'b0;
                w_state_nx    = IDLE;
            end
            default: begin
                w_operando_nx = 1'b0;
                w_state_nx    = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            operando <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            r_rem    <= w_rem_nx;
            r_quo    <= w_quo_nx;
            r_dvs    <= w_dvs_nx;
            r_cnt    <= w_cnt_nx;
            r_qsign  <= w_qsign_nx;
            r_rsign  <= w_rsign_nx;
            hi       <= w_hi_nx;
            lo       <= w_lo_nx;
            operando <= w_operando_nx;
            div_zero <= w_div_zero_nx;
        end
    end

endmodule : div

// File: tb/tb_div.sv
// Self-checking bench for div: vector table, random vectors against a 64-bit
// reference model, and hand-written back-to-back and mid-run reset sequences.
module tb_div;

    logic        clk;
    logic        reset;
    logic [31:0] x;
    logic [31:0] y;
    logic        div_control;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        operando;
    logic        div_zero;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[13];
    int          checks;
    int          errors;
    logic [31:0] held_lo;
    logic [31:0] held_hi;

    div dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .div_control(div_control),
        .hi         (hi),
        .lo         (lo),
        .operando   (operando),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            e.lo = held_lo;
            e.hi = held_hi;
            e.dz = 1'b1;
        end else begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            q    = sa / sb;
            r    = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Counts busy cycles until operando drops (negedge sampling)
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (operando === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d required=33", cnt);
        end
    endtask

    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e);
        int   cnt;
        exp_t got;
        sb_q.push_back(e);
        @(negedge clk);
        x           = a;
        y           = b;
        div_control = 1'b1;
        @(negedge clk);
        div_control = 1'b0;
        x           = $urandom;
        y           = $urandom;
        chk({nm, "_busy_start"}, {31'd0, operando}, {31'd0, ~e.dz});
        wait_done(cnt);
        got = sb_q.pop_front();
        chk({nm, "_lo"}, lo, got.lo);
        chk({nm, "_hi"}, hi, got.hi);
        chk({nm, "_dz"}, {31'd0, div_zero}, {31'd0, got.dz});
        chk({nm, "_busy_cycles"}, 32'(cnt), got.dz ? 32'd0 : 32'd33);
        held_lo = got.lo;
        held_hi = got.hi;
    endtask

    initial begin
        int   cnt;
        exp_t e;
        logic [31:0] ra;
        logic [31:0] rb;
        checks      = 0;
        errors      = 0;
        held_lo     = 32'd0;
        held_hi     = 32'd0;
        reset       = 1'b0;
        x           = 32'd0;
        y           = 32'd0;
        div_control = 1'b0;

        tbl[0]  = '{32'd100,        32'd7,          '{32'd14,         32'd2,          1'b0}};
        tbl[1]  = '{32'hFFFFFF9C,   32'd7,          '{32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0}};
        tbl[2]  = '{32'd100,        32'hFFFFFFF9,   '{32'hFFFFFFF2,   32'd2,          1'b0}};
        tbl[3]  = '{32'h80000000,   32'hFFFFFFFF,   '{32'h80000000,   32'd0,          1'b0}};
        tbl[4]  = '{32'd5,          32'd0,          '{32'h80000000,   32'd0,          1'b1}};
        tbl[5]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   '{32'd14,         32'hFFFFFFFE,   1'b0}};
        tbl[6]  = '{32'd7,          32'd100,        '{32'd0,          32'd7,          1'b0}};
        tbl[7]  = '{32'd0,          32'd5,          '{32'd0,          32'd0,          1'b0}};
        tbl[8]  = '{32'h7FFFFFFF,   32'd1,          '{32'h7FFFFFFF,   32'd0,          1'b0}};
        tbl[9]  = '{32'h80000000,   32'd1,          '{32'h80000000,   32'd0,          1'b0}};
        tbl[10] = '{32'h80000000,   32'h80000000,   '{32'd1,          32'd0,          1'b0}};
        tbl[11] = '{32'd1,          32'h80000000,   '{32'd0,          32'd1,          1'b0}};
        tbl[12] = '{32'hFFFFFFFF,   32'd2,          '{32'd0,          32'hFFFFFFFF,   1'b0}};

        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, operando}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].e);
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ($urandom & 32'h000000FF) : $urandom;
            if (i == 7) begin
                rb = 32'd0;
            end
            e = model(ra, rb);
            do_op($sformatf("rnd%0d", i), ra, rb, e);
        end

        // Back-to-back: div_control held high; operand changes mid-run are ignored
        sb_q.push_back(model(32'd100, 32'd7));
        @(negedge clk);
        x           = 32'd100;
        y           = 32'd7;
        div_control = 1'b1;
        @(negedge clk);
        x           = 32'd9;
        y           = 32'd3;
        chk("b2b_busy0", {31'd0, operando}, 32'd1);
        wait_done(cnt);
        chk("b2b_cycles0", 32'(cnt), 32'd33);
        e = sb_q.pop_front();
        chk("b2b_lo0", lo, e.lo);
        chk("b2b_hi0", hi, e.hi);
        sb_q.push_back(model(32'd9, 32'd3));
        @(negedge clk);
        chk("b2b_busy1", {31'd0, operando}, 32'd1);
        div_control = 1'b0;
        wait_done(cnt);
        chk("b2b_cycles1", 32'(cnt), 32'd33);
        e = sb_q.pop_front();
        chk("b2b_lo1", lo, e.lo);
        chk("b2b_hi1", hi, e.hi);

        // Reset in the middle of a run clears everything without a clock edge
        @(negedge clk);
        x           = 32'd100;
        y           = 32'd7;
        div_control = 1'b1;
        @(negedge clk);
        div_control = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", {31'd0, operando}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", {31'd0, operando}, 32'd0);
        chk("midrst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        chk("midrst_hold_lo", lo, 32'd0);
        reset   = 1'b1;
        held_lo = 32'd0;
        held_hi = 32'd0;
        do_op("after_rst", 32'd9, 32'd3, '{32'd3, 32'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div
